// File: rtl/wash_panel_ctrl.sv
// Coin-operated wash panel: synchronizes and debounces the panel inputs, then
// sequences one wash through IDLE -> COIN -> RUN -> DONE (or FAULT on timeout).
module wash_panel_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned DONE_HOLD       = 16,
  parameter logic [31:0] RUN_TIMEOUT     = 32'd1000
) (
  input  logic clk,
  input  logic rst,
  input  logic coin_btn,
  input  logic dbl_sw,
  input  logic pause_btn,
  input  logic wash_done,
  output logic coin_in,
  output logic double_wash,
  output logic timer_pause,
  output logic busy,
  output logic done_led,
  output logic fault
);
  localparam int NIN      = 3;
  localparam int NBTN     = 2;
  localparam int IN_COIN  = 0;
  localparam int IN_PAUSE = 1;
  localparam int IN_DBL   = 2;

  typedef enum logic [2:0] {S_IDLE, S_COIN, S_RUN, S_DONE, S_FAULT} state_t;

  logic [NIN-1:0]  raw_in;
  logic [NBTN-1:0] ev_w;
  logic [1:0]      valid_q, valid_d;
  logic            dbl_deb;
  logic            coin_ev, pause_ev;

  assign raw_in   = {dbl_sw, pause_btn, coin_btn};
  assign valid_d  = {valid_q[0], 1'b1};
  assign coin_ev  = ev_w[IN_COIN];
  assign pause_ev = ev_w[IN_PAUSE];

  // valid_q[1] marks that the synchronizers now hold samples taken after reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) valid_q <= '0;
    else     valid_q <= valid_d;
  end

  genvar gi;
  generate
    for (gi = 0; gi < NIN; gi++) begin : g_in
      logic       meta_q, sync_q, deb_q, deb_d;
      logic [7:0] cnt_q, cnt_d;

      always_comb begin
        deb_d = deb_q;
        cnt_d = '0;
        if (sync_q != deb_q) begin
          if (cnt_q == 8'(DEBOUNCE_CYCLES - 1)) deb_d = sync_q;
          else                                  cnt_d = cnt_q + 8'd1;
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          meta_q <= 1'b0;
          sync_q <= 1'b0;
          deb_q  <= 1'b0;
          cnt_q  <= '0;
        end else begin
          meta_q <= raw_in[gi];
          sync_q <= meta_q;
          deb_q  <= deb_d;
          cnt_q  <= cnt_d;
        end
      end

      if (gi < NBTN) begin : g_btn
        // A button only arms once it has been seen released after reset,
        // so a press held through reset never produces an event.
        logic prev_q, armed_q, armed_d;
        assign armed_d = armed_q | (valid_q[1] & ~sync_q);
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            prev_q  <= 1'b0;
            armed_q <= 1'b0;
          end else begin
            prev_q  <= deb_q;
            armed_q <= armed_d;
          end
        end
        assign ev_w[gi] = deb_q & ~prev_q & armed_q;
      end

      if (gi == IN_DBL) begin : g_lvl
        assign dbl_deb = deb_q;
      end
    end
  endgenerate

  state_t      state_q, state_d;
  logic [31:0] run_cnt_q, run_cnt_d, run_cnt_inc;
  logic [15:0] hold_cnt_q, hold_cnt_d;
  logic        wd_prev_q, wd_prev_d, wd_edge;
  logic        coin_in_q, coin_in_d, dw_q, dw_d, tp_q, tp_d;
  logic        busy_q, busy_d, done_q, done_d, fault_q, fault_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      run_cnt_q  <= '0;
      hold_cnt_q <= '0;
      wd_prev_q  <= 1'b0;
      coin_in_q  <= 1'b0;
      dw_q       <= 1'b0;
      tp_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      run_cnt_q  <= run_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      wd_prev_q  <= wd_prev_d;
      coin_in_q  <= coin_in_d;
      dw_q       <= dw_d;
      tp_q       <= tp_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      fault_q    <= fault_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    run_cnt_d   = run_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    tp_d        = tp_q;
    dw_d        = dw_q;
    // Outside RUN the previous sample reads as high, so a level already
    // present on RUN entry is never mistaken for a completion edge.
    wd_prev_d   = (state_q == S_RUN) ? wash_done : 1'b1;
    wd_edge     = (state_q == S_RUN) & wash_done & ~wd_prev_q;
    run_cnt_inc = run_cnt_q + {31'd0, ~tp_q};
    case (state_q)
      S_IDLE: begin
        dw_d = 1'b0;
        if (coin_ev) begin
          state_d = S_COIN;
          dw_d    = dbl_deb;
        end
      end
      S_COIN: begin
        state_d   = S_RUN;
        run_cnt_d = '0;
        tp_d      = 1'b0;
      end
      S_RUN: begin
        run_cnt_d = run_cnt_inc;
        if (wd_edge) begin
          state_d    = S_DONE;
          tp_d       = 1'b0;
          hold_cnt_d = '0;
        end else if (run_cnt_inc == RUN_TIMEOUT) begin
          state_d = S_FAULT;
          tp_d    = 1'b0;
        end else if (pause_ev) begin
          tp_d = ~tp_q;
        end
      end
      S_DONE: begin
        if (hold_cnt_q == 16'(DONE_HOLD - 1)) begin
          state_d = S_IDLE;
          dw_d    = 1'b0;
        end else begin
          hold_cnt_d = hold_cnt_q + 16'd1;
        end
      end
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    coin_in_d = (state_d == S_COIN);
    busy_d    = (state_d == S_COIN) || (state_d == S_RUN);
    done_d    = (state_d == S_DONE);
    fault_d   = (state_d == S_FAULT);
  end

  assign coin_in     = coin_in_q;
  assign double_wash = dw_q;
  assign timer_pause = tp_q;
  assign busy        = busy_q;
  assign done_led    = done_q;
  assign fault       = fault_q;

endmodule
